// File: rtl/iob_bitpack_ctrl.sv
// Bit-field packer: appends variable-length fields into DATA_W-bit words, splitting at word boundaries.
// Optional build macro IOB_BITPACK_MSB_FIRST_EN selects MSB-first (left-justified) packing.
module iob_bitpack_ctrl #(
   parameter  int DATA_W = 32,
   localparam int LEN_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              field_valid_i,
   output logic              field_ready_o,
   input  logic [DATA_W-1:0] field_data_i,
   input  logic [LEN_W-1:0]  field_len_i,
   input  logic              field_last_i,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   output logic [DATA_W-1:0] word_data_o,
   output logic [LEN_W-1:0]  word_bits_o
);

   localparam int SUM_W = LEN_W + 1;
   localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
   localparam logic [LEN_W-1:0]    ZERO_L   = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0]    FULL_L   = LEN_W'(DATA_W);
   localparam logic [SUM_W-1:0]    FULL_S   = SUM_W'(DATA_W);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   // Low-bit mask of the given width, evaluated at double width so len==DATA_W yields all ones.
   function automatic logic [DATA_W-1:0] low_mask(input logic [LEN_W-1:0] len);
      logic [2*DATA_W-1:0] one_w;
      logic [2*DATA_W-1:0] diff_w;
      one_w  = {{(2*DATA_W-1){1'b0}}, 1'b1} << len;
      diff_w = one_w - {{(2*DATA_W-1){1'b0}}, 1'b1};
      return diff_w[DATA_W-1:0];
   endfunction

   state_t              state_r, state_n;
   logic [DATA_W-1:0]   acc_r, acc_n;
   logic [LEN_W-1:0]    fill_r, fill_n;
   logic                word_valid_r, word_valid_n;
   logic [DATA_W-1:0]   word_data_r, word_data_n;
   logic [LEN_W-1:0]    word_bits_r, word_bits_n;

   logic                slot_free_s;
   logic                field_ready_s;
   logic                accept_s;
   logic [LEN_W-1:0]    len_clamp_s;
   logic [DATA_W-1:0]   masked_s;
   logic [SUM_W-1:0]    total_s;
   logic [2*DATA_W-1:0] wide_s;
   logic [DATA_W-1:0]   cur_word_s;
   logic [DATA_W-1:0]   spill_s;
`ifdef IOB_BITPACK_MSB_FIRST_EN
   logic [SUM_W-1:0]    shift_s;
`endif

   // Handshake qualifiers and field placement into a double-width window.
   always_comb begin
      slot_free_s   = ~word_valid_r | word_ready_i;
      field_ready_s = cke_i & (state_r == ST_RUN) & slot_free_s;
      accept_s      = field_valid_i & field_ready_s;
      len_clamp_s   = (field_len_i > FULL_L) ? FULL_L : field_len_i;
      masked_s      = field_data_i & low_mask(len_clamp_s);
      total_s       = {1'b0, fill_r} + {1'b0, len_clamp_s};
`ifdef IOB_BITPACK_MSB_FIRST_EN
      // Current word is the upper half; the field's top bit lands at DATA_W-1-fill.
      shift_s    = SUM_W'(2*DATA_W) - total_s;
      wide_s     = {acc_r, ZERO_W} | ({ZERO_W, masked_s} << shift_s);
      cur_word_s = wide_s[2*DATA_W-1:DATA_W];
      spill_s    = wide_s[DATA_W-1:0];
`else
      wide_s     = {ZERO_W, acc_r} | ({ZERO_W, masked_s} << fill_r);
      cur_word_s = wide_s[DATA_W-1:0];
      spill_s    = wide_s[2*DATA_W-1:DATA_W];
`endif
   end

   // Next-state: accumulate, emit full/partial words, and drain the spill remainder on FLUSH.
   always_comb begin
      state_n      = state_r;
      acc_n        = acc_r;
      fill_n       = fill_r;
      word_valid_n = word_valid_r & ~word_ready_i;
      word_data_n  = word_data_r;
      word_bits_n  = word_bits_r;
      case (state_r)
         ST_RUN: begin
            if (accept_s) begin
               if (total_s < FULL_S) begin
                  if (field_last_i) begin
                     if (total_s != {SUM_W{1'b0}}) begin
                        word_valid_n = 1'b1;
                        word_data_n  = cur_word_s;
                        word_bits_n  = total_s[LEN_W-1:0];
                     end else begin
                        word_valid_n = word_valid_r & ~word_ready_i;
                     end
                     acc_n  = ZERO_W;
                     fill_n = ZERO_L;
                  end else begin
                     acc_n  = cur_word_s;
                     fill_n = total_s[LEN_W-1:0];
                  end
               end else if (total_s == FULL_S) begin
                  word_valid_n = 1'b1;
                  word_data_n  = cur_word_s;
                  word_bits_n  = FULL_L;
                  acc_n        = ZERO_W;
                  fill_n       = ZERO_L;
               end else begin
                  word_valid_n = 1'b1;
                  word_data_n  = cur_word_s;
                  word_bits_n  = FULL_L;
                  acc_n        = spill_s;
                  fill_n       = LEN_W'(total_s - FULL_S);
                  state_n      = field_last_i ? ST_FLUSH : ST_RUN;
               end
            end else begin
               state_n = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (slot_free_s && cke_i) begin
               word_valid_n = 1'b1;
               word_data_n  = acc_r;
               word_bits_n  = fill_r;
               acc_n        = ZERO_W;
               fill_n       = ZERO_L;
               state_n      = ST_RUN;
            end else begin
               state_n = ST_FLUSH;
            end
         end
         default: begin
            state_n = ST_RUN;
         end
      endcase
   end

   // State and output registers; cke_i low freezes everything, rst_i clears under cke_i.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_r      <= ST_RUN;
         acc_r        <= ZERO_W;
         fill_r       <= ZERO_L;
         word_valid_r <= 1'b0;
         word_data_r  <= ZERO_W;
         word_bits_r  <= ZERO_L;
      end else if (cke_i) begin
         if (rst_i) begin
            state_r      <= ST_RUN;
            acc_r        <= ZERO_W;
            fill_r       <= ZERO_L;
            word_valid_r <= 1'b0;
            word_data_r  <= ZERO_W;
            word_bits_r  <= ZERO_L;
         end else begin
            state_r      <= state_n;
            acc_r        <= acc_n;
            fill_r       <= fill_n;
            word_valid_r <= word_valid_n;
            word_data_r  <= word_data_n;
            word_bits_r  <= word_bits_n;
         end
      end
   end

   assign field_ready_o = field_ready_s;
   assign word_valid_o  = word_valid_r;
   assign word_data_o   = word_data_r;
   assign word_bits_o   = word_bits_r;

endmodule

// File: tb/tb_iob_bitpack_ctrl.sv
// Directed self-checking bench for iob_bitpack_ctrl; expected words follow IOB_BITPACK_MSB_FIRST_EN.
module tb_iob_bitpack_ctrl;

   logic        clk_i = 1'b0;
   logic        arst_n_i;
   logic        cke_i;
   logic        rst_i;
   logic        field_valid_i;
   logic        field_ready_o;
   logic [31:0] field_data_i;
   logic [5:0]  field_len_i;
   logic        field_last_i;
   logic        word_valid_o;
   logic        word_ready_i;
   logic [31:0] word_data_o;
   logic [5:0]  word_bits_o;

   int errors = 0;
   int checks = 0;

`ifdef IOB_BITPACK_MSB_FIRST_EN
   localparam logic [31:0] E_FILL   = 32'hABCD1234;
   localparam logic [31:0] E_SPILL  = 32'hFFFFFFAB;
   localparam logic [31:0] E_FLUSH  = 32'hCD000000;
   localparam logic [31:0] E_MASK   = 32'hF0000000;
   localparam logic [31:0] E_BP0    = 32'hAB000000;
   localparam logic [31:0] E_BP1    = 32'h55000000;
   localparam logic [31:0] E_RST    = 32'h50000000;
   localparam logic [31:0] E_CKE    = 32'h91000000;
   localparam logic [31:0] E_SRST   = 32'hC0000000;
   localparam logic [31:0] E_ZLEN   = 32'h60000000;
   localparam logic [31:0] E_PART   = 32'hABCD0000;
`else
   localparam logic [31:0] E_FILL   = 32'h1234CDAB;
   localparam logic [31:0] E_SPILL  = 32'hCDFFFFFF;
   localparam logic [31:0] E_FLUSH  = 32'h000000AB;
   localparam logic [31:0] E_MASK   = 32'h0000000F;
   localparam logic [31:0] E_BP0    = 32'h000000AB;
   localparam logic [31:0] E_BP1    = 32'h00000055;
   localparam logic [31:0] E_RST    = 32'h00000005;
   localparam logic [31:0] E_CKE    = 32'h00000019;
   localparam logic [31:0] E_SRST   = 32'h0000000C;
   localparam logic [31:0] E_ZLEN   = 32'h00000006;
   localparam logic [31:0] E_PART   = 32'h0000CDAB;
`endif

   iob_bitpack_ctrl #(.DATA_W(32)) dut (
      .clk_i         (clk_i),
      .arst_n_i      (arst_n_i),
      .cke_i         (cke_i),
      .rst_i         (rst_i),
      .field_valid_i (field_valid_i),
      .field_ready_o (field_ready_o),
      .field_data_i  (field_data_i),
      .field_len_i   (field_len_i),
      .field_last_i  (field_last_i),
      .word_valid_o  (word_valid_o),
      .word_ready_i  (word_ready_i),
      .word_data_o   (word_data_o),
      .word_bits_o   (word_bits_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] d, input logic [5:0] b);
      chk({tag, "_valid"}, {31'd0, word_valid_o}, 32'd1);
      chk({tag, "_data"}, word_data_o, d);
      chk({tag, "_bits"}, {26'd0, word_bits_o}, {26'd0, b});
   endtask

   // Present one field for a single cycle; outputs are sampled 1 ns after the edge.
   task automatic send(input logic [31:0] d, input logic [5:0] l, input logic lst);
      field_data_i  = d;
      field_len_i   = l;
      field_last_i  = lst;
      field_valid_i = 1'b1;
      @(posedge clk_i); #1;
      field_valid_i = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk_i); #1;
   endtask

   initial begin
      arst_n_i = 1'b0; cke_i = 1'b1; rst_i = 1'b0; word_ready_i = 1'b1;
      field_valid_i = 1'b0; field_data_i = 32'd0; field_len_i = 6'd0; field_last_i = 1'b0;
      idle(); idle();
      chk("rst_valid", {31'd0, word_valid_o}, 32'd0);
      chk("rst_data", word_data_o, 32'd0);
      chk("rst_bits", {26'd0, word_bits_o}, 32'd0);
      arst_n_i = 1'b1; #1;
      chk("rst_ready", {31'd0, field_ready_o}, 32'd1);

      // exact word fill, back-to-back
      send(32'h000000AB, 6'd8, 1'b0);
      chk("fill_nowrd1", {31'd0, word_valid_o}, 32'd0);
      send(32'h000000CD, 6'd8, 1'b0);
      chk("fill_nowrd2", {31'd0, word_valid_o}, 32'd0);
      send(32'h00001234, 6'd16, 1'b0);
      chk_word("fill", E_FILL, 6'd32);
      idle();
      chk("fill_handoff", {31'd0, word_valid_o}, 32'd0);

      // spill followed by flush
      send(32'h00FFFFFF, 6'd24, 1'b0);
      send(32'h0000ABCD, 6'd16, 1'b1);
      chk_word("spill", E_SPILL, 6'd32);
      chk("flush_ready", {31'd0, field_ready_o}, 32'd0);
      idle();
      chk_word("flush", E_FLUSH, 6'd8);
      chk("post_flush_ready", {31'd0, field_ready_o}, 32'd1);

      // masking and length clamp
      send(32'hFFFFFFFF, 6'd4, 1'b1);
      chk_word("mask", E_MASK, 6'd4);
      send(32'h12345678, 6'd40, 1'b1);
      chk_word("clamp", 32'h12345678, 6'd32);
      idle();

      // backpressure then handoff with same-cycle accept
      word_ready_i = 1'b0;
      send(32'h000000AB, 6'd8, 1'b1);
      chk_word("bp_pend", E_BP0, 6'd8);
      field_data_i = 32'h00000055; field_len_i = 6'd8; field_last_i = 1'b1; field_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ready", {31'd0, field_ready_o}, 32'd0);
         chk("bp_stable", word_data_o, E_BP0);
         @(posedge clk_i); #1;
      end
      word_ready_i = 1'b1; #1;
      chk("bp_ready_comb", {31'd0, field_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      field_valid_i = 1'b0;
      chk_word("bp_new", E_BP1, 6'd8);
      idle();

      // async reset mid-stream with a word pending
      word_ready_i = 1'b0;
      send(32'h00000003, 6'd4, 1'b0);
      send(32'h00000007, 6'd4, 1'b1);
      arst_n_i = 1'b0; #1;
      chk("arst_valid", {31'd0, word_valid_o}, 32'd0);
      chk("arst_data", word_data_o, 32'd0);
      chk("arst_bits", {26'd0, word_bits_o}, 32'd0);
      arst_n_i = 1'b1; word_ready_i = 1'b1; #1;
      chk("arst_ready", {31'd0, field_ready_o}, 32'd1);
      send(32'h00000005, 6'd4, 1'b1);
      chk_word("arst_fill0", E_RST, 6'd4);

      // clock enable freeze
      send(32'h00000009, 6'd4, 1'b0);
      cke_i = 1'b0;
      field_data_i = 32'h00000001; field_len_i = 6'd4; field_last_i = 1'b1; field_valid_i = 1'b1;
      #1;
      chk("cke_ready", {31'd0, field_ready_o}, 32'd0);
      idle(); idle(); idle();
      chk("cke_hold", {31'd0, word_valid_o}, 32'd0);
      cke_i = 1'b1; #1;
      chk("cke_ready_on", {31'd0, field_ready_o}, 32'd1);
      @(posedge clk_i); #1;
      field_valid_i = 1'b0;
      chk_word("cke", E_CKE, 6'd8);

      // synchronous clear discards pending word and partial fill
      send(32'h00000009, 6'd4, 1'b0);
      word_ready_i = 1'b0;
      send(32'h00000002, 6'd4, 1'b1);
      chk("srst_pend", {31'd0, word_valid_o}, 32'd1);
      rst_i = 1'b1;
      idle();
      rst_i = 1'b0;
      chk("srst_valid", {31'd0, word_valid_o}, 32'd0);
      chk("srst_data", word_data_o, 32'd0);
      chk("srst_bits", {26'd0, word_bits_o}, 32'd0);
      word_ready_i = 1'b1;
      send(32'h0000000C, 6'd4, 1'b1);
      chk_word("srst_next", E_SRST, 6'd4);

      // zero-length fields
      send(32'hFFFFFFFF, 6'd0, 1'b1);
      chk("zlen_empty", {31'd0, word_valid_o}, 32'd0);
      send(32'h00000006, 6'd4, 1'b0);
      send(32'h000000FF, 6'd0, 1'b1);
      chk_word("zlen_last", E_ZLEN, 6'd4);

      // partial word ordering
      send(32'h000000AB, 6'd8, 1'b0);
      send(32'h000000CD, 6'd8, 1'b1);
      chk_word("partial", E_PART, 6'd16);
      idle();
      chk("end_idle", {31'd0, word_valid_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iob_bitpack_ctrl.md
Name: iob_bitpack_ctrl

Overview:
- Sequencer that packs a stream of variable-length bit fields into fixed DATA_W-bit output words.
- Each field is masked to its low field_len_i bits with a low-bit mask, (1<<len)-1, saturating at all-ones.
- Fields are appended at the current fill position. Fields that cross a word boundary are split between consecutive words.
- Sits between posit/float field encoders (sign, regime, exponent, fraction) and word-oriented storage or bus logic.

Parameters:
- DATA_W, 32, output word width and maximum field width (power of two, >= 8).
- LEN_W, $clog2(DATA_W)+1, width of length/count fields. Derived; not overridden.

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  asynchronous active-low reset
- cke_i  in  1  clock enable; low freezes all state
- rst_i  in  1  synchronous clear, qualified by cke_i
- field_valid_i  in  1  field offered
- field_ready_o  out  1  field accepted when valid&ready&cke_i
- field_data_i  in  DATA_W  field value, right-justified; bits at or above len are ignored
- field_len_i  in  LEN_W  field length in bits; values above DATA_W clamp to DATA_W
- field_last_i  in  1  flush after this field
- word_valid_o  out  1  output word pending
- word_ready_i  in  1  consumer accepts the word
- word_data_o  out  DATA_W  packed word
- word_bits_o  out  LEN_W  number of valid bits in word_data_o (DATA_W for full words)

Behaviour:
- Async reset: state RUN, acc=0, fill=0, word_valid_o=0, word_data_o=0, word_bits_o=0.
- Sync rst_i with cke_i: same values; any pending word is discarded.
- cke_i low: all registers hold and field_ready_o=0.
- Output slot: one register. The slot is free when !word_valid_o or word_ready_i.
- field_ready_o = cke_i & (state==RUN) & slot free. This is a combinational path from word_ready_i, which is allowed.
- Word handoff occurs on word_valid_o&word_ready_i. word_valid_o clears unless a new word is loaded in the same cycle.
- Field accept (L = min(len,DATA_W), m = data & mask(L), T = fill+L):
  - T < DATA_W, last=0: acc |= m<<fill; fill=T; no output.
  - T < DATA_W, last=1, T>0: emit acc|(m<<fill) with bits=T; acc=0; fill=0.
  - T < DATA_W, last=1, T=0: no word emitted; fill stays 0.
  - T == DATA_W: emit acc|(m<<fill) with bits=DATA_W; acc=0; fill=0 (regardless of last).
  - T > DATA_W: emit low DATA_W bits of acc|(m<<fill) with bits=DATA_W; acc = m>>(DATA_W-fill); fill=T-DATA_W.
  - T > DATA_W with last=1: additionally enter FLUSH.
- FLUSH: field_ready_o=0. When the slot is free, emit acc with bits=fill, clear acc and fill, return to RUN.
- Latency: the emitted word is visible the cycle after the accepting edge. Back-to-back fields sustain one field per cycle while word_ready_i stays high.
- L=0 fields: no bit changes; only the last semantics apply.
- Shift amounts are computed at 2*DATA_W width. No bits are lost.
- Unused high bits of partial words are zero.

Optional Feature:
- Macro: IOB_BITPACK_MSB_FIRST_EN.
- Undefined: LSB-first packing as above.
- Defined: MSB-first packing.
  - Field occupies bits [DATA_W-1-fill -: L], keeping its own MSB highest.
  - On a spill, the upper DATA_W-fill field bits complete the current word. The remaining low bits start the next word at bit DATA_W-1.
  - Partial words are left-justified; word_bits_o has the same meaning.
  - Handshake, FSM and counts are unchanged.

Test Plan:
- Reset: assert arst_n_i mid-stream with word pending, then release with cke_i=1 -> word_valid_o=0, word_bits_o=0, field_ready_o=1; next field starts at fill 0.
- Fill exact word: (0xAB,len 8),(0xCD,8),(0x1234,16), word_ready_i=1 -> one word 0x1234CDAB, bits 32, one cycle after the third accept.
- Spill plus flush: (0xFFFFFF,24) then (0xABCD,16,last) -> 0xCDFFFFFF bits 32, then 0x000000AB bits 8. field_ready_o is low during FLUSH.
- Masking and clamp: (0xFFFFFFFF,4,last) -> 0x0000000F bits 4. Then (0x12345678,40,last) -> 0x12345678 bits 32.
- Backpressure: word pending with word_ready_i=0 for 5 cycles -> field_ready_o=0 and word_data_o stable. Raise word_ready_i with field_valid_i=1 -> handoff and new accept in the same cycle.
- IOB_BITPACK_MSB_FIRST_EN defined: (0xAB,8),(0xCD,8,last) -> 0xABCD0000 bits 16.
